// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, stall encodings, ALU op bits, divider states and the decoded EX bundle
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;
    localparam int HILO_WD      = 66;
    localparam int STALL_WD     = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;

    // alu_op bit positions, MSB first
    localparam int OP_ADD  = 11;
    localparam int OP_SUB  = 10;
    localparam int OP_SLT  = 9;
    localparam int OP_SLTU = 8;
    localparam int OP_AND  = 7;
    localparam int OP_NOR  = 6;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 4;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 2;
    localparam int OP_SRA  = 1;
    localparam int OP_LUI  = 0;

    localparam logic [5:0] FUNC_DIV  = 6'h1A;
    localparam logic [5:0] FUNC_DIVU = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_src1;
        logic [3:0]  sel_src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    function automatic logic is_div_inst(input logic [31:0] inst);
        return (inst[31:26] == 6'd0) && ((inst[5:0] == FUNC_DIV) || (inst[5:0] == FUNC_DIVU));
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// rtl/ex_stage_div_iter.sv - iterative restoring divider (div_iter), present only when EX_DIVIDER_EN is defined
// Ports: clk_i, rst_i (sync active-high), start_i, signed_i, dividend_i, divisor_i,
//        busy_o (stall request, includes the start cycle), done_o (one cycle), quot_o, rem_o
`ifdef EX_DIVIDER_EN
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    div_state_e  state_q, state_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // partial remainder with the next dividend bit shifted in, and trial subtraction
    logic [32:0] shifted;
    logic [32:0] diff;
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvsr_q};

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                busy_o = start_i;
                if (start_i) begin
                    rem_d     = 32'd0;
                    quo_d     = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
                    dvsr_d    = (signed_i && divisor_i[31])  ? -divisor_i  : divisor_i;
                    neg_quo_d = signed_i && (dividend_i[31] ^ divisor_i[31]);
                    neg_rem_d = signed_i && dividend_i[31];
                    cnt_d     = '0;
                    state_d   = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                busy_o = 1'b1;
                // divisor of zero always "fits": quotient fills with ones, remainder ends as the dividend
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                done_o  = 1'b1;
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= DIV_IDLE;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign quot_o = neg_quo_q ? -quo_q : quo_q;
    assign rem_o  = neg_rem_q ? -rem_q : rem_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: EX register, operand select, ALU, data SRAM request, optional divider
// Ports: clk, rst (sync active-high), stall[5:0], stallreq_for_ex, id_to_ex_bus[158:0],
//        ex_to_mem_bus[75:0], ex_to_id_bus[37:0], hilo_bus[65:0], data_sram_en/wen/addr/wdata
// Option: EX_DIVIDER_EN enables the div/divu unit; otherwise divides are nops and stallreq/hilo are 0.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    output logic                    stallreq_for_ex,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic [HILO_WD-1:0]      hilo_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_to_ex_t ex_q, ex_d;

    always_comb begin
        ex_d = ex_q;
        if (stall[STALL_ID] == STOP && stall[STALL_EX] == NO_STOP) begin
            ex_d = '0;
        end else if (stall[STALL_EX] == NO_STOP) begin
            ex_d = id_to_ex_t'(id_to_ex_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    logic [31:0] src1, src2, ex_result;

    // selects are one-hot; an empty select yields zero
    assign src1 = ({32{ex_q.sel_src1[0]}} & ex_q.rdata1)
                | ({32{ex_q.sel_src1[1]}} & ex_q.pc)
                | ({32{ex_q.sel_src1[2]}} & {27'd0, ex_q.inst[10:6]});

    assign src2 = ({32{ex_q.sel_src2[0]}} & ex_q.rdata2)
                | ({32{ex_q.sel_src2[1]}} & {{16{ex_q.inst[15]}}, ex_q.inst[15:0]})
                | ({32{ex_q.sel_src2[2]}} & 32'd8)
                | ({32{ex_q.sel_src2[3]}} & {16'd0, ex_q.inst[15:0]});

    logic [4:0] sa;
    assign sa = src1[4:0];

    assign ex_result = ({32{ex_q.alu_op[OP_ADD]}}  & (src1 + src2))
                     | ({32{ex_q.alu_op[OP_SUB]}}  & (src1 - src2))
                     | ({32{ex_q.alu_op[OP_SLT]}}  & {31'd0, $signed(src1) < $signed(src2)})
                     | ({32{ex_q.alu_op[OP_SLTU]}} & {31'd0, src1 < src2})
                     | ({32{ex_q.alu_op[OP_AND]}}  & (src1 & src2))
                     | ({32{ex_q.alu_op[OP_NOR]}}  & ~(src1 | src2))
                     | ({32{ex_q.alu_op[OP_OR]}}   & (src1 | src2))
                     | ({32{ex_q.alu_op[OP_XOR]}}  & (src1 ^ src2))
                     | ({32{ex_q.alu_op[OP_SLL]}}  & (src2 << sa))
                     | ({32{ex_q.alu_op[OP_SRL]}}  & (src2 >> sa))
                     | ({32{ex_q.alu_op[OP_SRA]}}  & 32'($signed(src2) >>> sa))
                     | ({32{ex_q.alu_op[OP_LUI]}}  & {src2[15:0], 16'd0});

    assign ex_to_mem_bus = {ex_q.pc, ex_q.ram_en, ex_q.ram_wen, ex_q.sel_rf_res,
                            ex_q.rf_we, ex_q.rf_waddr, ex_result};
    assign ex_to_id_bus  = {ex_q.rf_we, ex_q.rf_waddr, ex_result};

    assign data_sram_en    = ex_q.ram_en;
    assign data_sram_wen   = ex_q.ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = ex_q.rdata2;

`ifdef EX_DIVIDER_EN
    logic        div_done;
    logic [31:0] div_quot, div_rem;

    div_iter #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div_iter (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (is_div_inst(ex_q.inst)),
        .signed_i   (ex_q.inst[5:0] == FUNC_DIV),
        .dividend_i (ex_q.rdata1),
        .divisor_i  (ex_q.rdata2),
        .busy_o     (stallreq_for_ex),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    assign hilo_bus = div_done ? {2'b11, div_rem, div_quot} : '0;
`else
    localparam int unused_div_cycles = DIV_CYCLES;
    logic unused_div_fields;
    assign unused_div_fields = ^{ex_q.inst[31:16], ex_q.inst[5:0]};

    assign stallreq_for_ex = 1'b0;
    assign hilo_bus        = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage: directed plan plus random ALU and divide traffic
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [STALL_WD-1:0]     stall;
    logic                    stallreq;
    logic [ID_TO_EX_WD-1:0]  id_bus;
    logic [EX_TO_MEM_WD-1:0] mem_bus;
    logic [EX_TO_ID_WD-1:0]  fwd_bus;
    logic [HILO_WD-1:0]      hilo;
    logic                    sram_en;
    logic [3:0]              sram_wen;
    logic [31:0]             sram_addr, sram_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .stallreq_for_ex (stallreq),
        .id_to_ex_bus    (id_bus),
        .ex_to_mem_bus   (mem_bus),
        .ex_to_id_bus    (fwd_bus),
        .hilo_bus        (hilo),
        .data_sram_en    (sram_en),
        .data_sram_wen   (sram_wen),
        .data_sram_addr  (sram_addr),
        .data_sram_wdata (sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference ALU: pick operands by select, then apply the one named operation
    function automatic logic [31:0] ref_alu(input id_to_ex_t d);
        logic [31:0] a, b;
        int unsigned sh;
        a = 32'd0;
        b = 32'd0;
        if (d.sel_src1[0]) a = d.rdata1;
        if (d.sel_src1[1]) a = d.pc;
        if (d.sel_src1[2]) a = 32'(d.inst[10:6]);
        if (d.sel_src2[0]) b = d.rdata2;
        if (d.sel_src2[1]) b = 32'($signed(d.inst[15:0]));
        if (d.sel_src2[2]) b = 32'd8;
        if (d.sel_src2[3]) b = 32'(d.inst[15:0]);
        sh = a % 32;
        if (d.alu_op[OP_ADD])  return a + b;
        if (d.alu_op[OP_SUB])  return a - b;
        if (d.alu_op[OP_SLT])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (d.alu_op[OP_SLTU]) return (a < b) ? 32'd1 : 32'd0;
        if (d.alu_op[OP_AND])  return a & b;
        if (d.alu_op[OP_NOR])  return ~(a | b);
        if (d.alu_op[OP_OR])   return a | b;
        if (d.alu_op[OP_XOR])  return a ^ b;
        if (d.alu_op[OP_SLL])  return 32'(64'(b) * (64'd1 << sh));
        if (d.alu_op[OP_SRL])  return b / (32'd1 << sh);
        if (d.alu_op[OP_SRA])  return 32'($signed(b) >>> sh);
        if (d.alu_op[OP_LUI])  return {b[15:0], 16'd0};
        return 32'd0;
    endfunction

    // reference divide: magnitudes with integer arithmetic, then sign rules; returns {hi, lo}
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, q, r;
        bit na, nb;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
        mb = nb ? (64'h1_0000_0000 - longint'(b)) : longint'(b);
        if (mb == 0) begin
            q = 64'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (na != nb) q = -q;
        if (na) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic id_to_ex_t div_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        id_to_ex_t d;
        d = '0;
        d.inst   = {6'd0, 5'd4, 5'd5, 10'd0, sgn ? FUNC_DIV : FUNC_DIVU};
        d.rdata1 = a;
        d.rdata2 = b;
        return d;
    endfunction

    function automatic id_to_ex_t rand_op();
        id_to_ex_t d;
        int k;
        d          = '0;
        d.pc       = $urandom;
        d.inst     = {6'($urandom_range(1, 63)), 26'($urandom)};
        d.rdata1   = $urandom;
        d.rdata2   = $urandom;
        d.ram_en   = 1'($urandom);
        d.ram_wen  = 4'($urandom);
        d.rf_we    = 1'($urandom);
        d.rf_waddr = 5'($urandom);
        d.sel_rf_res = 1'($urandom);
        k = $urandom_range(0, 12);
        if (k < 12) d.alu_op[k] = 1'b1;
        k = $urandom_range(0, 3);
        if (k < 3) d.sel_src1[k] = 1'b1;
        k = $urandom_range(0, 4);
        if (k < 4) d.sel_src2[k] = 1'b1;
        return d;
    endfunction

`ifdef EX_DIVIDER_EN
    // issue a divide, count stalled cycles, check the one-cycle hilo write and release
    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int n;
        stall  = '0;
        id_bus = div_op(sgn, a, b);
        step();
        id_bus = '0;
        n = 0;
        while (stallreq && n < 100) begin
            check({tag, "_fwd_we"}, 76'(fwd_bus[37]), 76'd0);
            n++;
            stall = 6'b001111;
            step();
        end
        check({tag, "_stall_cycles"}, 76'(n), 76'(33));
        check({tag, "_hilo"}, 76'(hilo), 76'({2'b11, ref_div(sgn, a, b)}));
        stall = '0;
        step();
        check({tag, "_after"}, 76'({stallreq, hilo}), 76'd0);
    endtask
`endif

    initial begin
        id_to_ex_t d;
        logic [31:0] r;
        bit seen;

        rst    = 1'b1;
        stall  = '0;
        id_bus = '0;
        step();
        step();
        check("reset_mem", 76'(mem_bus), 76'd0);
        check("reset_misc", 76'({stallreq, fwd_bus}), 76'd0);
        check("reset_hilo", 76'(hilo), 76'd0);
        check("reset_sram", 76'({sram_en, sram_wen, sram_addr, sram_wdata}), 76'd0);
        rst = 1'b0;

        // addu r3 = 5 + 7
        d = '0;
        d.alu_op[OP_ADD] = 1'b1;
        d.sel_src1 = 3'b001;
        d.sel_src2 = 4'b0001;
        d.rdata1 = 32'd5;
        d.rdata2 = 32'd7;
        d.rf_we = 1'b1;
        d.rf_waddr = 5'd3;
        id_bus = d;
        step();
        check("addu_fwd", 76'(fwd_bus), 76'({1'b1, 5'd3, 32'd12}));

        // jal link value pc + 8
        d = '0;
        d.alu_op[OP_ADD] = 1'b1;
        d.pc = 32'hBFC0_0010;
        d.sel_src1 = 3'b010;
        d.sel_src2 = 4'b0100;
        id_bus = d;
        step();
        check("jal_result", 76'(mem_bus[31:0]), 76'(32'hBFC0_0018));

        // EX held: new input must not enter
        stall  = 6'b001111;
        id_bus = rand_op();
        step();
        check("hold_result", 76'(mem_bus[31:0]), 76'(32'hBFC0_0018));
        check("hold_pc", 76'(mem_bus[75:44]), 76'(32'hBFC0_0010));

        // decode held, EX released: bubble
        stall = 6'b000111;
        step();
        check("bubble_mem", 76'(mem_bus), 76'd0);
        check("bubble_rest", 76'({stallreq, hilo, fwd_bus, sram_en, sram_wen, sram_addr, sram_wdata}), 76'd0);

        // sw-style request
        stall = '0;
        d = '0;
        d.alu_op[OP_ADD] = 1'b1;
        d.sel_src1 = 3'b001;
        d.sel_src2 = 4'b0010;
        d.inst = {6'h2B, 5'd1, 5'd2, 16'hFFFC};
        d.rdata1 = 32'h100;
        d.rdata2 = 32'hDEAD;
        d.ram_en = 1'b1;
        d.ram_wen = 4'hF;
        id_bus = d;
        step();
        check("sw_addr", 76'(sram_addr), 76'(32'hFC));
        check("sw_wdata", 76'(sram_wdata), 76'(32'hDEAD));
        check("sw_en_wen", 76'({sram_en, sram_wen}), 76'(5'h1F));

        // random ALU traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            d = rand_op();
            id_bus = d;
            step();
            r = ref_alu(d);
            check("rand_mem", 76'(mem_bus),
                  76'({d.pc, d.ram_en, d.ram_wen, d.sel_rf_res, d.rf_we, d.rf_waddr, r}));
            check("rand_fwd", 76'(fwd_bus), 76'({d.rf_we, d.rf_waddr, r}));
            check("rand_sram", 76'({sram_en, sram_wen, sram_addr, sram_wdata}),
                  76'({d.ram_en, d.ram_wen, r, d.rdata2}));
        end

`ifdef EX_DIVIDER_EN
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("divu_9_0", 1'b0, 32'd9, 32'd0);
        run_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_div("div_rand", 1'($urandom), $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom);
        end

        // reset in the middle of a divide
        id_bus = div_op(1'b0, 32'd1000, 32'd3);
        step();
        id_bus = '0;
        stall  = 6'b001111;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        check("rst_busy_stallreq", 76'(stallreq), 76'd0);
        rst   = 1'b0;
        stall = '0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (hilo != '0 || stallreq) seen = 1'b1;
        end
        check("rst_busy_no_write", 76'(seen), 76'd0);
`else
        // divider absent: divides are nops
        id_bus = div_op(1'b0, 32'd100, 32'd7);
        step();
        check("nodiv_stallreq", 76'(stallreq), 76'd0);
        check("nodiv_hilo", 76'(hilo), 76'd0);
        check("nodiv_result", 76'(fwd_bus), 76'd0);
        id_bus = '0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (hilo != '0 || stallreq) seen = 1'b1;
        end
        check("nodiv_quiet", 76'(seen), 76'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
